md4_msg_padder: RTL and testbench
=================================

Name: md4_msg_padder

Overview:
- Upstream feeder for the MD4 round datapath (stage1/stage2/stage3 + assemble).
- Accepts a message as a byte stream with valid/ready and applies MD4 padding: 0x80 byte, zero fill, 64-bit bit-length.
- Emits 512-bit blocks in the exact M layout the round stages consume, one block per handshake.
- Supports arbitrary-length messages of 1 or more bytes and back-to-back messages.

Parameters:
- LEN_W, 64, width of the internal bit-length counter. Must be 64; M[63:0] is always fully driven.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  padder accepts a byte this cycle
- in_data  input  8  message byte
- in_last  input  1  final byte of message; qualified by in_valid
- blk_valid  output  1  blk_data holds a complete block
- blk_ready  input  1  consumer takes the block
- blk_data  output  512  padded block; byte i of the block at blk_data[511-8i -: 8]
- blk_last  output  1  final block of the message; qualified by blk_valid

Behaviour:
- Reset (rst=1 at a rising edge): blk_valid=0, blk_last=0, blk_data=0, in_ready=0 in that cycle, byte index=0, length counter=0, state=FILL.
  - Reset mid-message or while a block is pending discards everything. No partial block is ever emitted.
  - in_ready=1 from the first cycle after rst deasserts.
- Handshakes: a transfer occurs when valid&&ready at a rising edge.
  - in_ready=1 only in FILL; it is 0 whenever blk_valid=1.
  - blk_data and blk_last are held stable while blk_valid && !blk_ready.
- States:
  - FILL: each accepted byte is written at byte index idx (0..63); idx++ and byte_cnt++.
    - Byte accepted with idx reaching 64 and in_last=0 -> EMIT_DATA (blk_last=0).
    - Byte accepted with in_last=1 -> let n = idx after the write (1..64):
      - n<=55: write 0x80 at byte n and the bit length at [63:0] -> EMIT_FINAL.
      - 56<=n<=63: write 0x80 at byte n; length pending -> EMIT_PAD1.
      - n=64: 0x80 and length both pending -> EMIT_DATA_P.
  - EMIT_DATA: blk_valid=1, blk_last=0. On handshake: clear buffer, idx=0 -> FILL.
  - EMIT_DATA_P: blk_valid=1, blk_last=0. On handshake: buffer becomes 0x80 at byte 0 plus length at [63:0] -> EMIT_FINAL.
  - EMIT_PAD1: blk_valid=1, blk_last=0. On handshake: buffer becomes all zero plus length at [63:0] -> EMIT_FINAL.
  - EMIT_FINAL: blk_valid=1, blk_last=1. On handshake: clear buffer, idx=0, byte_cnt=0 -> FILL.
- Latency:
  - blk_valid rises the cycle after the accepting edge of the 64th byte or the last byte.
  - A follow-on padding block is presented the cycle after the previous block's handshake, so there is no bubble.
- Length field:
  - Bit length = byte_cnt*8, mod 2^64.
  - Stored as an unsigned value in blk_data[63:0] (LSB at bit 0). This matches the M encoding used by the round stages.
  - byte_cnt wraps silently.
- Zero fill: every byte not written with data, 0x80, or length reads 0. The buffer is cleared on every block handshake.
- in_last is ignored when in_valid=0. A message of 0 bytes is not representable.
- Simultaneous rst with any handshake: rst wins.

Test Plan:
- "Ahmad" (41 68 6D 61 64, last on 0x64), blk_ready=1 -> one block 512'h41686D6164800…0028, blk_last=1, blk_valid the cycle after the last accept, in_ready=0 during the block.
- 56 bytes 0x00..0x37 -> block 1: the bytes, then 0x80 at byte 56, zeros to the end, blk_last=0. Block 2: all zero except [63:0]=0x1C0, blk_last=1, presented one cycle after block 1's handshake.
- 64 bytes 0xAA -> block 1: all 0xAA, blk_last=0. Block 2: byte 0 = 0x80, [63:0]=0x200, blk_last=1.
- 70-byte message with blk_ready held low for 5 cycles on each block -> blk_data/blk_last stable, in_ready=0 throughout, the final block carries [63:0]=0x230, no bytes lost or duplicated.
- 30 bytes fed, then rst pulsed for one cycle, then "abc" -> no block for the aborted message. Output is 616263 80 00… with [63:0]=0x18, blk_last=1.
- Back-to-back messages: 1-byte 0x00, then "a" with no idle cycles -> block 00 80 00…[63:0]=0x8, then block 61 80 00…[63:0]=0x8. Both have blk_last=1; the length counter restarts between them.

Source files
------------

// File: rtl/md4_msg_padder_if.sv
// Byte-stream input and 512-bit block output handshakes of the MD4 message padder.
interface md4_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;

  // Source of message bytes and consumer of padded blocks.
  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output blk_ready,
    input  in_ready,
    input  blk_valid,
    input  blk_data,
    input  blk_last
  );

  // The padder itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  blk_ready,
    output in_ready,
    output blk_valid,
    output blk_data,
    output blk_last
  );
endinterface

// File: rtl/md4_msg_padder.sv
// MD4 message padder: collects message bytes into a 512-bit block buffer, appends the
// 0x80 marker, zero fill and the 64-bit bit length, and hands out blocks in the M layout
// used by the round stages (byte i at blk_data[511-8i -: 8], length in blk_data[63:0]).
module md4_msg_padder #(
  parameter int unsigned LEN_W = 64  // must stay 64 so blk_data[63:0] is fully driven
) (
  input  logic        clk,
  input  logic        rst,
  md4_msg_padder_if.slave bus
);

  typedef enum logic [2:0] {
    StFill,
    StEmitData,   // full data block, message continues
    StEmitDataP,  // full data block, 0x80 and length still owed
    StEmitPad1,   // block ends with 0x80, length still owed
    StEmitFinal   // block carrying the length
  } state_e;

  state_e             state_q, state_d;
  logic [511:0]       blk_q, blk_d;
  logic [6:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               blk_valid_q, blk_valid_d;
  logic               blk_last_q, blk_last_d;

  logic [6:0]         idx_nxt;
  logic [LEN_W-1:0]   cnt_inc;
  logic [LEN_W-1:0]   len_now;  // bit length including the byte accepted this cycle
  logic [LEN_W-1:0]   len_old;  // bit length of the bytes already counted

  assign idx_nxt = idx_q + 7'd1;
  assign cnt_inc = cnt_q + 1'b1;
  assign len_now = cnt_inc << 3;
  assign len_old = cnt_q << 3;

  // in_ready is decoded from state; rst forces it low during the reset cycle.
  assign bus.in_ready  = (state_q == StFill) && !rst;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_last  = blk_last_q;
  assign bus.blk_data  = blk_q;

  // Next-state, buffer update and registered-output decode.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StFill: begin
        if (bus.in_valid) begin
          for (int i = 0; i < 64; i++) begin
            if (idx_q == 7'(i)) begin
              blk_d[511-8*i -: 8] = bus.in_data;
            end
            // Marker lands right after the last byte when it still fits in this block.
            if (bus.in_last && (idx_nxt == 7'(i))) begin
              blk_d[511-8*i -: 8] = 8'h80;
            end
          end
          idx_d = idx_nxt;
          cnt_d = cnt_inc;
          if (bus.in_last) begin
            if (idx_nxt <= 7'd55) begin
              blk_d[63:0] = len_now;
              state_d     = StEmitFinal;
            end else if (idx_nxt <= 7'd63) begin
              state_d = StEmitPad1;
            end else begin
              state_d = StEmitDataP;
            end
          end else if (idx_nxt == 7'd64) begin
            state_d = StEmitData;
          end
        end
      end
      StEmitData: begin
        if (bus.blk_ready) begin
          blk_d   = '0;
          idx_d   = '0;
          state_d = StFill;
        end
      end
      StEmitDataP: begin
        if (bus.blk_ready) begin
          blk_d          = '0;
          blk_d[511:504] = 8'h80;
          blk_d[63:0]    = len_old;
          state_d        = StEmitFinal;
        end
      end
      StEmitPad1: begin
        if (bus.blk_ready) begin
          blk_d       = '0;
          blk_d[63:0] = len_old;
          state_d     = StEmitFinal;
        end
      end
      StEmitFinal: begin
        if (bus.blk_ready) begin
          blk_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase

    blk_valid_d = (state_d != StFill);
    blk_last_d  = (state_d == StEmitFinal);
  end

  // State and output registers; reset discards any partial message or pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      blk_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      blk_valid_q <= blk_valid_d;
      blk_last_q  <= blk_last_d;
    end
  end

endmodule

// File: tb/tb_md4_msg_padder.sv
// Directed bench for md4_msg_padder with hand-computed expected blocks.
module tb_md4_msg_padder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md4_msg_padder_if bus ();

  logic blk_rdy = 1'b1;
  assign bus.blk_ready = blk_rdy;

  md4_msg_padder #(.LEN_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [7:0]   msg [0:127];
  logic [511:0] got_data [$];
  logic         got_last [$];
  int           got_cyc  [$];

  bit stall_mode = 1'b0;
  int stall_cnt  = 0;

  logic         stalled = 1'b0;
  logic [511:0] held_data;
  logic         held_last;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Consumer: always ready, or in stall mode hold each block for 5 cycles first.
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      blk_rdy = 1'b1;
    end else if (bus.blk_valid) begin
      if (stall_cnt >= 5) begin
        blk_rdy   = 1'b1;
        stall_cnt = 0;
      end else begin
        blk_rdy = 1'b0;
        stall_cnt++;
      end
    end else begin
      blk_rdy   = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: record block handshakes, check hold-while-stalled and in_ready exclusion.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (bus.blk_valid) check_eq("in_ready_during_blk", {511'd0, bus.in_ready}, 512'd0);
      if (stalled) begin
        check_eq("hold_valid", {511'd0, bus.blk_valid}, 512'd1);
        check_eq("hold_data", bus.blk_data, held_data);
        check_eq("hold_last", {511'd0, bus.blk_last}, {511'd0, held_last});
      end
      stalled   = bus.blk_valid && !bus.blk_ready;
      held_data = bus.blk_data;
      held_last = bus.blk_last;
      if (bus.blk_valid && bus.blk_ready) begin
        got_data.push_back(bus.blk_data);
        got_last.push_back(bus.blk_last);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (t == 400) begin
      check_eq("in_ready_timeout", {511'd0, bus.in_ready}, 512'd1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_byte(msg[i], (i == n - 1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input string tag, input int k);
    for (int t = 0; t < 400 && got_data.size() < k; t++) @(negedge clk);
    check_eq({tag, "_nblk"}, 512'(got_data.size()), 512'(k));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  logic [511:0] exp1;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", {511'd0, bus.in_ready}, 512'd0);
    check_eq("rst_blk_valid", {511'd0, bus.blk_valid}, 512'd0);
    check_eq("rst_blk_last", {511'd0, bus.blk_last}, 512'd0);
    check_eq("rst_blk_data", bus.blk_data, 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("in_ready_after_rst", {511'd0, bus.in_ready}, 512'd1);
    @(posedge clk);
    #1;

    // "Ahmad": single final block, blk_valid the cycle after the last accept
    clear_q();
    msg[0] = 8'h41; msg[1] = 8'h68; msg[2] = 8'h6D; msg[3] = 8'h61; msg[4] = 8'h64;
    send_msg(5);
    @(negedge clk);
    check_eq("t1_lat_valid", {511'd0, bus.blk_valid}, 512'd1);
    check_eq("t1_lat_in_ready", {511'd0, bus.in_ready}, 512'd0);
    wait_blocks("t1", 1);
    if (got_data.size() >= 1) begin
      check_eq("t1_data", got_data[0],
               {8'h41, 8'h68, 8'h6D, 8'h61, 8'h64, 8'h80, 400'd0, 64'h28});
      check_eq("t1_last", {511'd0, got_last[0]}, 512'd1);
    end

    // 56 bytes: marker fills byte 56, length spills to a second block
    clear_q();
    for (int i = 0; i < 56; i++) msg[i] = 8'(i);
    send_msg(56);
    wait_blocks("t2", 2);
    exp1 = '0;
    for (int i = 0; i < 56; i++) exp1[511-8*i -: 8] = 8'(i);
    exp1[63:56] = 8'h80;
    if (got_data.size() >= 2) begin
      check_eq("t2_b1_data", got_data[0], exp1);
      check_eq("t2_b1_last", {511'd0, got_last[0]}, 512'd0);
      check_eq("t2_b2_data", got_data[1], {448'd0, 64'h1C0});
      check_eq("t2_b2_last", {511'd0, got_last[1]}, 512'd1);
      check_eq("t2_no_bubble", 512'(got_cyc[1] - got_cyc[0]), 512'd1);
    end

    // 64 bytes 0xAA: marker and length both in the second block
    clear_q();
    for (int i = 0; i < 64; i++) msg[i] = 8'hAA;
    send_msg(64);
    wait_blocks("t3", 2);
    if (got_data.size() >= 2) begin
      check_eq("t3_b1_data", got_data[0], {64{8'hAA}});
      check_eq("t3_b1_last", {511'd0, got_last[0]}, 512'd0);
      check_eq("t3_b2_data", got_data[1], {8'h80, 440'd0, 64'h200});
      check_eq("t3_b2_last", {511'd0, got_last[1]}, 512'd1);
      check_eq("t3_no_bubble", 512'(got_cyc[1] - got_cyc[0]), 512'd1);
    end

    // 70 bytes with the consumer stalling 5 cycles on each block
    clear_q();
    stall_mode = 1'b1;
    for (int i = 0; i < 70; i++) msg[i] = 8'(i + 1);
    send_msg(70);
    wait_blocks("t4", 2);
    stall_mode = 1'b0;
    exp1 = '0;
    for (int i = 0; i < 64; i++) exp1[511-8*i -: 8] = 8'(i + 1);
    if (got_data.size() >= 2) begin
      check_eq("t4_b1_data", got_data[0], exp1);
      check_eq("t4_b1_last", {511'd0, got_last[0]}, 512'd0);
      check_eq("t4_b2_data", got_data[1],
               {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h80, 392'd0, 64'h230});
      check_eq("t4_b2_last", {511'd0, got_last[1]}, 512'd1);
    end
    repeat (3) @(posedge clk);
    #1;

    // 30 bytes, reset pulse, then "abc": aborted message must vanish
    clear_q();
    for (int i = 0; i < 30; i++) msg[i] = 8'hC0 + 8'(i);
    for (int i = 0; i < 30; i++) send_byte(msg[i], 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_in_ready", {511'd0, bus.in_ready}, 512'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t5_in_ready_after", {511'd0, bus.in_ready}, 512'd1);
    check_eq("t5_no_block", 512'(got_data.size()), 512'd0);
    check_eq("t5_valid_low", {511'd0, bus.blk_valid}, 512'd0);
    @(posedge clk);
    #1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3);
    wait_blocks("t5", 1);
    if (got_data.size() >= 1) begin
      check_eq("t5_data", got_data[0], {8'h61, 8'h62, 8'h63, 8'h80, 416'd0, 64'h18});
      check_eq("t5_last", {511'd0, got_last[0]}, 512'd1);
    end

    // Back-to-back one-byte messages, in_valid held between them
    clear_q();
    send_byte(8'h00, 1'b1);
    send_byte(8'h61, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_blocks("t6", 2);
    if (got_data.size() >= 2) begin
      check_eq("t6_b1_data", got_data[0], {8'h00, 8'h80, 432'd0, 64'h8});
      check_eq("t6_b1_last", {511'd0, got_last[0]}, 512'd1);
      check_eq("t6_b2_data", got_data[1], {8'h61, 8'h80, 432'd0, 64'h8});
      check_eq("t6_b2_last", {511'd0, got_last[1]}, 512'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
